// File: rtl/regfile_pkg.sv
// regfile_pkg: types and default parameters shared by the register file
// and its clear sequencer.
package regfile_pkg;

  // Clear-sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // LSB position of port p inside a flat bus of w-bit fields
  function automatic int port_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: walks entries 1..DEPTH-1 one per clock and emits a
// zeroing write for each. Entry 0 is never stored, so it is skipped.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for clr_req; clr_busy low
//   CLEAR | zeroing entry cnt each edge; returns to IDLE after DEPTH-1
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // Clear FSM: state, address counter and registered busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= ADDR_W'(1);
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = clr_busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a per-entry busy
// scoreboard and a sequenced bulk clear. Entry 0 reads as zero.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok  = wr_en && (wr_addr != '0);
  assign iss_ok = issue_en && (issue_addr != '0);

  regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Storage and scoreboard update; the clear owns the array while it runs,
  // and an issue overrides a same-cycle write's busy release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '{default: '0};
      busy <= '0;
    end else if (clr_we) begin
      mem[clr_addr]  <= '0;
      busy[clr_addr] <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr]  <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (iss_ok) begin
        busy[issue_addr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];

    // Read mux for one port, with optional forwarding of the in-flight write
    always_comb begin
      d = mem[a];
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && !clr_busy && (a == wr_addr)) begin
        d = wr_data;
        b = iss_ok && (issue_addr == a);
      end
`endif
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[port_lsb(p, DATA_W) +: DATA_W] = d;
    assign rd_busy[p]                              = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp, default build
// plus a DATA_W=64 / ADDR_W=3 / NUM_RD=4 instance.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int BDW = 64;
  localparam int BAW = 3;
  localparam int BNR = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              issue_en = 1'b0;
  logic [AW-1:0]     issue_addr = '0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              clr_req = 1'b0;
  logic              clr_busy;

  logic              b_wr_en = 1'b0;
  logic [BAW-1:0]    b_wr_addr = '0;
  logic [BDW-1:0]    b_wr_data = '0;
  logic              b_issue_en = 1'b0;
  logic [BAW-1:0]    b_issue_addr = '0;
  logic [BNR*BAW-1:0] b_rd_addr = '0;
  logic [BNR*BDW-1:0] b_rd_data;
  logic [BNR-1:0]    b_rd_busy;
  logic              b_clr_req = 1'b0;
  logic              b_clr_busy;

  regfile_mp dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.DATA_W(BDW), .ADDR_W(BAW), .NUM_RD(BNR)) dut_big (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy), .clr_req(b_clr_req), .clr_busy(b_clr_busy)
  );

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic logic [63:0] observe(input int kind, input int port);
    case (kind)
      0:       return 64'(rd_data[port*DW +: DW]);
      1:       return 64'(rd_busy[port]);
      2:       return 64'(clr_busy);
      3:       return b_rd_data[port*BDW +: BDW];
      default: return 64'(b_clr_busy);
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input int kind, input int port, input logic [63:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, observe(e.kind, e.port), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic write(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic issue(input int a);
    issue_en = 1'b1; issue_addr = AW'(a);
    step();
    issue_en = 1'b0;
  endtask

  function automatic logic [31:0] fillv(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0111;
  endfunction

  function automatic logic [63:0] bigv(input int i);
    return {32'hCAFE_0000 | 32'(i), 32'(i) * 32'h0101_0101};
  endfunction

  // Pulse (or hold) clr_req and count cycles of clr_busy on the small instance.
  task automatic run_clear(input string tag, input int hold, input bit poke);
    int n_hi;
    n_hi = 0;
    clr_req = 1'b1;
    step();
    for (int c = 0; c < 40; c++) begin
      if (c == hold) clr_req = 1'b0;
      if (poke && c == 0) begin
        set_rd(0, 1); set_rd(1, 31);
        expect_v("clr_r1_pending", 0, 0, 64'(fillv(1)));
        expect_v("clr_r31_pending", 0, 1, 64'(fillv(31)));
        drain();
      end
      if (poke && c == 1) begin
        expect_v("clr_r1_zeroed", 0, 0, 64'h0);
        drain();
      end
      if (poke && c == 4) begin
        wr_en = 1'b1; wr_addr = AW'(1); wr_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_addr = AW'(1);
        expect_v("clr_no_bypass_data", 0, 0, 64'h0);
        expect_v("clr_no_bypass_busy", 1, 0, 64'h0);
        drain();
      end
      if (poke && c == 5) begin
        wr_en = 1'b0; issue_en = 1'b0;
        expect_v("clr_wr_dropped", 0, 0, 64'h0);
        expect_v("clr_issue_dropped", 1, 0, 64'h0);
        drain();
      end
      if (clr_busy !== 1'b1) break;
      n_hi++;
      step();
    end
    clr_req = 1'b0;
    wr_en = 1'b0; issue_en = 1'b0;
    cmp(tag, 64'(n_hi), 64'd31);
  endtask

  initial begin
    int n_hi;

    // Reset state
    step(); step();
    set_rd(0, 5); set_rd(1, 31);
    expect_v("rst_data0", 0, 0, 64'h0);
    expect_v("rst_data1", 0, 1, 64'h0);
    expect_v("rst_busy0", 1, 0, 64'h0);
    expect_v("rst_clr_busy", 2, 0, 64'h0);
    expect_v("rst_big_clr_busy", 4, 0, 64'h0);
    drain();
    rst = 1'b0;
    step();

    // Write r5, read next cycle; r0 writes are dropped
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEAD_BEEF;
    expect_v("wr_r5_same_cycle", 0, 0, BYP ? 64'hDEAD_BEEF : 64'h0);
    drain();
    step();
    wr_en = 1'b0;
    expect_v("wr_r5_next", 0, 0, 64'hDEAD_BEEF);
    drain();
    set_rd(1, 0);
    write(0, 32'h1234);
    expect_v("r0_data", 0, 1, 64'h0);
    expect_v("r0_busy", 1, 1, 64'h0);
    drain();

    // Issue r7, then write it
    set_rd(0, 7);
    issue(7);
    expect_v("iss_r7_busy", 1, 0, 64'h1);
    drain();
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h55;
    expect_v("wr_r7_busy_same", 1, 0, BYP ? 64'h0 : 64'h1);
    expect_v("wr_r7_data_same", 0, 0, BYP ? 64'h55 : 64'h0);
    drain();
    step();
    wr_en = 1'b0;
    expect_v("wr_r7_busy_after", 1, 0, 64'h0);
    expect_v("wr_r7_data_after", 0, 0, 64'h55);
    drain();

    // Issue and write r9 in one cycle: issue wins
    set_rd(0, 9);
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h99;
    issue_en = 1'b1; issue_addr = AW'(9);
    expect_v("iw_r9_busy_same", 1, 0, BYP ? 64'h1 : 64'h0);
    expect_v("iw_r9_data_same", 0, 0, BYP ? 64'h99 : 64'h0);
    drain();
    step();
    wr_en = 1'b0; issue_en = 1'b0;
    expect_v("iw_r9_busy", 1, 0, 64'h1);
    expect_v("iw_r9_data", 0, 0, 64'h99);
    drain();

    // Same-cycle read of a register being written on port 1
    set_rd(1, 3);
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'hA5A5_A5A5;
    expect_v("byp_r3_same", 0, 1, BYP ? 64'hA5A5_A5A5 : 64'h0);
    drain();
    step();
    wr_en = 1'b0;
    expect_v("byp_r3_next", 0, 1, 64'hA5A5_A5A5);
    drain();

    // Fill, mark some busy, verify contents
    for (int i = 1; i < 32; i++) write(i, fillv(i));
    issue(2); issue(4); issue(6);
    for (int i = 1; i < 32; i++) begin
      set_rd(0, i); set_rd(1, i);
      expect_v("fill_data", 0, 0, 64'(fillv(i)));
      expect_v("fill_busy", 1, 1, (i == 2 || i == 4 || i == 6) ? 64'h1 : 64'h0);
      drain();
    end

    // Bulk clear with a dropped write/issue mid-sequence
    run_clear("clr_len", 0, 1'b1);
    expect_v("clr_done_flag", 2, 0, 64'h0);
    drain();
    for (int i = 0; i < 32; i++) begin
      set_rd(0, i); set_rd(1, i);
      expect_v("clr_all_data", 0, 0, 64'h0);
      expect_v("clr_all_busy", 1, 1, 64'h0);
      drain();
    end

    // Reset in the middle of a clear
    for (int i = 10; i < 32; i++) write(i, fillv(i));
    issue(25);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    set_rd(0, 30); set_rd(1, 25);
    expect_v("midclr_busy_before", 2, 0, 64'h1);
    expect_v("midclr_r30_before", 0, 0, 64'(fillv(30)));
    expect_v("midclr_r25_busy_before", 1, 1, 64'h1);
    drain();
    rst = 1'b1;
    expect_v("midrst_clr_busy", 2, 0, 64'h0);
    expect_v("midrst_r30", 0, 0, 64'h0);
    expect_v("midrst_r25", 0, 1, 64'h0);
    expect_v("midrst_r25_busy", 1, 1, 64'h0);
    drain();
    step();
    rst = 1'b0;
    step();
    expect_v("postrst_r30", 0, 0, 64'h0);
    expect_v("postrst_clr_busy", 2, 0, 64'h0);
    drain();
    // clr_req held for a few extra cycles is ignored while clearing
    run_clear("clr_len_after_rst", 3, 1'b0);
    step();
    expect_v("clr_no_restart", 2, 0, 64'h0);
    drain();

    // Wide/shallow/four-port instance
    for (int i = 1; i < 8; i++) begin
      b_wr_en = 1'b1; b_wr_addr = BAW'(i); b_wr_data = bigv(i);
      step();
    end
    b_wr_en = 1'b0;
    b_rd_addr = {3'd2, 3'd4, 3'd1, 3'd7};
    expect_v("big_p0_r7", 3, 0, bigv(7));
    expect_v("big_p1_r1", 3, 1, bigv(1));
    expect_v("big_p2_r4", 3, 2, bigv(4));
    expect_v("big_p3_r2", 3, 3, bigv(2));
    drain();
    b_rd_addr = {3'd0, 3'd3, 3'd6, 3'd5};
    expect_v("big_p0_r5", 3, 0, bigv(5));
    expect_v("big_p1_r6", 3, 1, bigv(6));
    expect_v("big_p2_r3", 3, 2, bigv(3));
    expect_v("big_p3_r0", 3, 3, 64'h0);
    drain();
    b_clr_req = 1'b1;
    step();
    b_clr_req = 1'b0;
    n_hi = 0;
    for (int c = 0; c < 20; c++) begin
      if (b_clr_busy !== 1'b1) break;
      n_hi++;
      step();
    end
    cmp("big_clr_len", 64'(n_hi), 64'd7);
    b_rd_addr = {3'd7, 3'd6, 3'd5, 3'd1};
    for (int p = 0; p < BNR; p++) expect_v("big_clr_data", 3, p, 64'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
